// File: rtl/serial_adder_4bit_if.sv
// Request/result bundle for the 4-bit bit-serial adder.
// Latency: n/a (wires only); the master drives operands and start, the slave returns S/Cout/busy/done.
// Backpressure: none; busy tells the master when start would be ignored.
interface serial_adder_4bit_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Cout;
  logic       busy;
  logic       done;

  modport master (
    output start, A, B, Cin,
    input  S, Cout, busy, done
  );

  modport slave (
    input  start, A, B, Cin,
    output S, Cout, busy, done
  );
endinterface

// File: rtl/serial_adder_4bit.sv
// Bit-serial 4-bit adder: {Cout,S} = A + B + Cin, one full-adder stage, LSB first.
// Latency: start accepted at edge N, done pulses in the cycle after edge N+5; one add per 6 cycles.
// Backpressure: start is only honoured in IDLE; while busy (ADD/DONE) it is ignored.
module serial_adder_4bit (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_4bit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] a_sh;     // augend shift register, consumed LSB first
  logic [3:0] b_sh;     // addend shift register, consumed LSB first
  logic [3:0] sum_sh;   // sum bits enter at the MSB, so after 4 shifts bit 0 is the LSB
  logic       carry;    // carry flip-flop feeding the single full-adder stage
  logic [1:0] bit_cnt;  // index of the bit being added in ADD

  logic fa_sum;
  logic fa_cout;

  // Single full-adder stage on the current LSBs plus the stored carry.
  always_comb begin
    fa_sum  = a_sh[0] ^ b_sh[0] ^ carry;
    fa_cout = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= 4'b0000;
      b_sh     <= 4'b0000;
      sum_sh   <= 4'b0000;
      carry    <= 1'b0;
      bit_cnt  <= 2'd0;
      bus.S    <= 4'b0000;
      bus.Cout <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the DONE branch raises it.
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Operands are snapshotted here so later input changes cannot disturb the add.
            a_sh     <= bus.A;
            b_sh     <= bus.B;
            carry    <= bus.Cin;
            sum_sh   <= 4'b0000;
            bit_cnt  <= 2'd0;
            bus.busy <= 1'b1;
            state    <= ADD;
          end
        end
        ADD: begin
          sum_sh  <= {fa_sum, sum_sh[3:1]};
          a_sh    <= {1'b0, a_sh[3:1]};
          b_sh    <= {1'b0, b_sh[3:1]};
          carry   <= fa_cout;
          bit_cnt <= bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Results only move here, so S/Cout hold steady through the next operation.
          bus.S    <= sum_sh;
          bus.Cout <= carry;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Directed bench for serial_adder_4bit: latency, busy window, overflow, operand capture,
// start-while-busy, continuous start, mid-add reset and a full 512-vector sweep.
// Inputs are driven and outputs sampled on the falling edge.
module tb_serial_adder_4bit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [4:0] last_res;  // {Cout,S} the DUT should be holding between DONE cycles

  serial_adder_4bit_if bus ();

  serial_adder_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request; watches 8 falling edges after the accepting edge.
  // meddle: scrambles the operands and pulses start while the add is in flight.
  task automatic do_add(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input bit meddle, input string tag);
    int lat;
    int busy_n;
    int pulses;
    logic [4:0] res;
    logic [4:0] exp;
    lat    = 0;
    busy_n = 0;
    pulses = 0;
    res    = 5'd0;
    exp    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    bus.start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (meddle && i == 2) begin
        bus.A     = 4'hA;
        bus.B     = 4'h5;
        bus.Cin   = 1'b1;
        bus.start = 1'b1;
      end
      if (meddle && i == 3) bus.start = 1'b0;
      if (i == 3) check({tag, "_hold"}, {27'd0, bus.Cout, bus.S}, {27'd0, last_res});
      if (bus.busy) busy_n++;
      if (bus.done) begin
        pulses++;
        if (lat == 0) begin
          lat = i;
          res = {bus.Cout, bus.S};
        end
      end
    end
    check({tag, "_lat"},    lat,    6);
    check({tag, "_busy"},   busy_n, 5);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_res"},    {27'd0, res}, {27'd0, exp});
    last_res = exp;
  endtask

  initial begin
    int pulses;
    int prev_idx;
    n_checks  = 0;
    n_errors  = 0;
    last_res  = 5'd0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = 4'd0;
    bus.B     = 4'd0;
    bus.Cin   = 1'b0;

    // Reset state, before any clock edge.
    #3;
    check("rst_S",    {28'd0, bus.S}, 32'd0);
    check("rst_Cout", {31'd0, bus.Cout}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic and overflow cases.
    do_add(4'd5, 4'd3, 1'b0, 1'b0, "5p3");
    do_add(4'hF, 4'h1, 1'b0, 1'b0, "Fp1");
    do_add(4'hF, 4'hF, 1'b1, 1'b0, "FpFc");
    repeat (3) @(negedge clk);
    check("idle_hold", {27'd0, bus.Cout, bus.S}, {27'd0, last_res});

    // Operands change and start re-pulses mid-add: captured 1+1 must win.
    do_add(4'd1, 4'd1, 1'b0, 1'b1, "capture");

    // start held high: one result every 6 cycles, never restarted while busy.
    @(negedge clk);
    bus.A     = 4'd2;
    bus.B     = 4'd2;
    bus.Cin   = 1'b0;
    bus.start = 1'b1;
    pulses    = 0;
    prev_idx  = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        check("stream_S", {28'd0, bus.S}, 32'd4);
        if (pulses > 1) check("stream_gap", i - prev_idx, 6);
        prev_idx = i;
      end
    end
    bus.start = 1'b0;
    check("stream_pulses", pulses, 3);
    check("stream_first", prev_idx, 18);
    last_res = 5'd4;
    repeat (8) @(negedge clk);

    // Reset during the second ADD cycle aborts with no done pulse.
    bus.A     = 4'd1;
    bus.B     = 4'd2;
    bus.Cin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_S",    {28'd0, bus.S}, 32'd0);
    check("abort_Cout", {31'd0, bus.Cout}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("abort_nodone", pulses, 0);
    last_res = 5'd0;
    do_add(4'd7, 4'd7, 1'b1, 1'b0, "7p7c");

    // Exhaustive sweep.
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vec;
      vec = v[8:0];
      do_add(vec[8:5], vec[4:1], vec[0], 1'b0, "sweep");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
